// File: rtl/host_comm_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : host_comm_master_pkg
//  Purpose  : Shared state encodings and frame constants for the host UART
//             command master and its receive path.
//  Revision : 1.0  initial release
// ============================================================================
package host_comm_master_pkg;

    typedef enum logic [1:0] {
        TX_IDLE    = 2'd0,
        TX_SEND_HI = 2'd1,
        TX_SEND_LO = 2'd2
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // start + 8 data + stop
    localparam int unsigned c_frame_bits = 10;

endpackage : host_comm_master_pkg
`default_nettype wire

// File: rtl/host_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : host_uart_rx
//  Purpose  : 8N1 UART receiver with 2-flop synchronizer, ready flag and
//             clear handshake.
//  Revision : 1.0  initial release
// ============================================================================
module host_uart_rx
    import host_comm_master_pkg::*;
#(
    parameter int BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    input  logic       i_clr_rdy,
    output logic       o_rdy,
    output logic [7:0] o_rx_data
);

    localparam int unsigned CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] c_baud_last = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] c_half_last = CW'(BAUD_DIV / 2 - 1);

    rx_state_t     state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic          rx_prev_q, rx_prev_d;
    logic [CW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          rdy_q, rdy_d;

    logic w_rx_s;
    logic w_fall;

    assign w_rx_s = sync_q[1];
    assign w_fall = rx_prev_q & ~w_rx_s;

    always_comb begin
        state_d    = state_q;
        sync_d     = {sync_q[0], i_rx};
        rx_prev_d  = w_rx_s;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        // A set later in this block overrides the clear
        rdy_d      = rdy_q & ~i_clr_rdy;

        case (state_q)
            RX_IDLE: begin
                if (w_fall) begin
                    state_d    = RX_START;
                    baud_cnt_d = '0;
                    rdy_d      = 1'b0;
                end
            end
            RX_START: begin
                if (baud_cnt_q == c_half_last) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = w_rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (baud_cnt_q == c_baud_last) begin
                    baud_cnt_d = '0;
                    shift_d    = {w_rx_s, shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (baud_cnt_q == c_baud_last) begin
                    baud_cnt_d = '0;
                    data_d     = shift_q;
                    rdy_d      = 1'b1;
                    state_d    = RX_IDLE;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RX_IDLE;
            sync_q     <= 2'b11;
            rx_prev_q  <= 1'b1;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            rx_prev_q  <= rx_prev_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            rdy_q      <= rdy_d;
        end
    end

    assign o_rdy     = rdy_q;
    assign o_rx_data = data_q;

endmodule : host_uart_rx
`default_nettype wire

// File: rtl/host_comm_master.sv
`default_nettype none
// ============================================================================
//  Module   : host_comm_master
//  Purpose  : Host-side UART command master: sends a 16-bit command as two
//             8N1 bytes (high first) and receives 8N1 response bytes.
//  Revision : 1.0  initial release
// ============================================================================
module host_comm_master
    import host_comm_master_pkg::*;
#(
    parameter int BAUD_DIV = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        cmd_cmplt,
    output logic        rdy,
    output logic [7:0]  rx_data,
    input  logic        clr_rdy
);

    localparam int unsigned CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] c_baud_last = CW'(BAUD_DIV - 1);
    localparam logic [3:0]    c_last_bit  = 4'(c_frame_bits - 1);

    tx_state_t     tx_state_q, tx_state_d;
    logic [CW-1:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [8:0]    shift_q, shift_d;
    logic [7:0]    lo_byte_q, lo_byte_d;
    logic          tx_q, tx_d;
    logic          cmd_cmplt_q, cmd_cmplt_d;

    always_comb begin
        tx_state_d  = tx_state_q;
        baud_cnt_d  = baud_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        lo_byte_d   = lo_byte_q;
        tx_d        = tx_q;
        cmd_cmplt_d = cmd_cmplt_q;

        case (tx_state_q)
            TX_IDLE: begin
                if (snd_cmd) begin
                    // Start bit goes out immediately; shift holds data + stop
                    tx_state_d  = TX_SEND_HI;
                    shift_d     = {1'b1, cmd[15:8]};
                    lo_byte_d   = cmd[7:0];
                    tx_d        = 1'b0;
                    cmd_cmplt_d = 1'b0;
                    baud_cnt_d  = '0;
                    bit_cnt_d   = '0;
                end
            end
            TX_SEND_HI, TX_SEND_LO: begin
                if (baud_cnt_q == c_baud_last) begin
                    baud_cnt_d = '0;
                    if (bit_cnt_q == c_last_bit) begin
                        bit_cnt_d = '0;
                        if (tx_state_q == TX_SEND_HI) begin
                            tx_state_d = TX_SEND_LO;
                            shift_d    = {1'b1, lo_byte_q};
                            tx_d       = 1'b0;
                        end else begin
                            tx_state_d  = TX_IDLE;
                            tx_d        = 1'b1;
                            cmd_cmplt_d = 1'b1;
                        end
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = {1'b1, shift_q[8:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q  <= TX_IDLE;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '1;
            lo_byte_q   <= '0;
            tx_q        <= 1'b1;
            cmd_cmplt_q <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            lo_byte_q   <= lo_byte_d;
            tx_q        <= tx_d;
            cmd_cmplt_q <= cmd_cmplt_d;
        end
    end

    assign TX        = tx_q;
    assign cmd_cmplt = cmd_cmplt_q;

    host_uart_rx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .i_rx      (RX),
        .i_clr_rdy (clr_rdy),
        .o_rdy     (rdy),
        .o_rx_data (rx_data)
    );

endmodule : host_comm_master
`default_nettype wire

// File: tb/tb_host_comm_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_host_comm_master
//  Purpose  : Directed self-checking bench for host_comm_master (BAUD_DIV=16).
//  Revision : 1.0  initial release
// ============================================================================
module tb_host_comm_master;

    localparam int BAUD_DIV = 16;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        snd_cmd = 1'b0;
    logic        clr_rdy = 1'b0;
    logic [15:0] cmd     = 16'h0000;
    logic        rx_drv  = 1'b1;
    logic        loop_en = 1'b1;
    logic        rx_line;
    logic        tx;
    logic        cmd_cmplt;
    logic        rdy;
    logic [7:0]  rx_data;

    int n_checks = 0;
    int n_fail   = 0;

    assign rx_line = loop_en ? tx : rx_drv;

    always #5 clk = ~clk;

    host_comm_master #(
        .BAUD_DIV (BAUD_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .RX        (rx_line),
        .TX        (tx),
        .cmd       (cmd),
        .snd_cmd   (snd_cmd),
        .cmd_cmplt (cmd_cmplt),
        .rdy       (rdy),
        .rx_data   (rx_data),
        .clr_rdy   (clr_rdy)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected TX level during bit k (0..19) of a two-byte command
    function automatic logic frame_bit(input logic [15:0] w, input int k);
        logic [7:0] b;
        int         j;
        b = (k < 10) ? w[15:8] : w[7:0];
        j = k % 10;
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return b[j-1];
    endfunction

    // Called at a negedge; returns at the negedge after the accepting posedge
    task automatic send(input logic [15:0] w);
        cmd     = w;
        snd_cmd = 1'b1;
        @(negedge clk);
        snd_cmd = 1'b0;
    endtask

    task automatic wait_rdy(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_cmplt(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cmd_cmplt === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic ok;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_tx", 16'(tx), 16'h1);
        check_eq("rst_cmplt", 16'(cmd_cmplt), 16'h0);
        check_eq("rst_rdy", 16'(rdy), 16'h0);
        check_eq("rst_rx_data", 16'(rx_data), 16'h00);
        rst = 1'b0;
        @(negedge clk);

        // A55A: bit-exact TX waveform and cmd_cmplt latency; cmd changes after latch
        send(16'hA55A);
        cmd = 16'h0000;
        check_eq("tx_start_now", 16'(tx), 16'h0);
        check_eq("cmplt_cleared", 16'(cmd_cmplt), 16'h0);
        for (int c = 1; c <= 20 * BAUD_DIV; c++) begin
            @(negedge clk);
            if (c % BAUD_DIV == BAUD_DIV / 2)
                check_eq($sformatf("tx_bit%0d", c / BAUD_DIV), 16'(tx),
                         16'(frame_bit(16'hA55A, c / BAUD_DIV)));
            if (c == 20 * BAUD_DIV - 1)
                check_eq("cmplt_early", 16'(cmd_cmplt), 16'h0);
            if (c == 20 * BAUD_DIV)
                check_eq("cmplt_on_time", 16'(cmd_cmplt), 16'h1);
        end
        check_eq("loop_a55a_rdy", 16'(rdy), 16'h1);
        check_eq("loop_a55a_data", 16'(rx_data), 16'h5A);
        check_eq("tx_idle_after", 16'(tx), 16'h1);

        // Loopback 1234 with a second snd_cmd (FFFF) during SEND_HI
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
        check_eq("clr_rdy_low", 16'(rdy), 16'h0);
        send(16'h1234);
        repeat (40) @(negedge clk);
        send(16'hFFFF);
        wait_rdy(300, ok);
        check_eq("rdy_hi_seen", 16'(ok), 16'h1);
        check_eq("rx_hi_byte", 16'(rx_data), 16'h12);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
        check_eq("rdy_after_clr", 16'(rdy), 16'h0);
        wait_rdy(300, ok);
        check_eq("rdy_lo_seen", 16'(ok), 16'h1);
        check_eq("rx_lo_byte", 16'(rx_data), 16'h34);
        wait_cmplt(100, ok);
        check_eq("cmplt_1234", 16'(ok), 16'h1);

        // Short RX glitch must be rejected
        loop_en = 1'b0;
        rx_drv  = 1'b1;
        repeat (5) @(negedge clk);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
        rx_drv  = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv  = 1'b1;
        repeat (20 * BAUD_DIV) @(negedge clk);
        check_eq("glitch_rdy", 16'(rdy), 16'h0);
        check_eq("glitch_data", 16'(rx_data), 16'h34);

        // Set wins over a simultaneous clr_rdy (clr_rdy held high throughout)
        loop_en = 1'b1;
        repeat (4) @(negedge clk);
        clr_rdy = 1'b1;
        send(16'hC33C);
        wait_rdy(200, ok);
        check_eq("set_wins", 16'(ok), 16'h1);
        check_eq("set_wins_data", 16'(rx_data), 16'hC3);
        @(negedge clk);
        check_eq("clr_next_cycle", 16'(rdy), 16'h0);
        clr_rdy = 1'b0;

        // Reset during the low byte's start bit
        repeat (10) @(negedge clk);
        check_eq("pre_rst_tx", 16'(tx), 16'h0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_tx", 16'(tx), 16'h1);
        check_eq("midrst_cmplt", 16'(cmd_cmplt), 16'h0);
        rst = 1'b0;
        repeat (20 * BAUD_DIV + 40) @(negedge clk);
        check_eq("postrst_tx", 16'(tx), 16'h1);
        check_eq("postrst_cmplt", 16'(cmd_cmplt), 16'h0);
        check_eq("postrst_rdy", 16'(rdy), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_host_comm_master
`default_nettype wire
